// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter sequencing a single-port 16x8 data memory
// (synchronous write, registered read) between the CPU LSU and the debug loader.
//
// state   | meaning
// IDLE    | waiting for a request; arbitrates and latches the winner
// ACCESS  | one strobe cycle (MemWrite or MemRead) at the latched address
// CAPTURE | read data arrives on dado_out and is stored in rdata of the port
// ACK     | one-cycle ack/err pulse to the granted port
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] dado_in,
  input  logic [DATA_W-1:0] dado_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

  state_t state;
  logic   last_grant;
  logic   cur_port;
  logic   cur_we;

  logic              gnt_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_bad;

  always_comb begin
    gnt_port = 1'b0;
    if (req0 && req1) gnt_port = ~last_grant;
    else if (req1)    gnt_port = 1'b1;
    sel_we    = gnt_port ? we1    : we0;
    sel_addr  = gnt_port ? addr1  : addr0;
    sel_wdata = gnt_port ? wdata1 : wdata0;
    addr_bad  = {1'b0, sel_addr} >= DEPTH_C;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      cur_we     <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      endereco   <= '0;
      dado_in    <= '0;
      busy       <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            cur_port   <= gnt_port;
            cur_we     <= sel_we;
            last_grant <= gnt_port;
            busy       <= 1'b1;
            if (addr_bad) begin
              state <= ACK;
              ack0  <= ~gnt_port;
              ack1  <= gnt_port;
              err0  <= ~gnt_port;
              err1  <= gnt_port;
            end else begin
              // endereco/dado_in double as the latched request copy
              state    <= ACCESS;
              endereco <= sel_addr;
              if (sel_we) begin
                MemWrite <= 1'b1;
                dado_in  <= sel_wdata;
              end else begin
                MemRead <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          if (cur_we) begin
            state <= ACK;
            ack0  <= ~cur_port;
            ack1  <= cur_port;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state <= ACK;
          ack0  <= ~cur_port;
          ack1  <= cur_port;
          if (cur_port) rdata1 <= dado_out;
          else          rdata0 <= dado_out;
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
